// File: rtl/read_line_burst_scheduler.sv
// Read-side line burst scheduler: requests full or tail bursts into the read-data FIFO
// whenever its fill is at or below THRESHOLD, with one burst outstanding and a WAIT watchdog.
module read_line_burst_scheduler #(
    parameter int THRESHOLD  = 200,
    parameter int FULL_LEN   = 256,
    parameter int LSIZE      = 9,
    parameter int FIFO_DEPTH = 512,
    parameter int TIMEOUT    = 4096
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic             fsync,
    input  logic [9:0]       count,
    input  logic             tail_status,
    input  logic [LSIZE-1:0] tail_len,
    output logic             burst_req,
    output logic             tail_req,
    output logic [LSIZE-1:0] req_len,
    input  logic             resp,
    input  logic             done,
    output logic             burst_done,
    output logic             tail_done,
    output logic             timeout
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARM   = 3'd1;
    localparam logic [2:0] BREQ  = 3'd2;
    localparam logic [2:0] BWAIT = 3'd3;
    localparam logic [2:0] TREQ  = 3'd4;
    localparam logic [2:0] TWAIT = 3'd5;

    localparam int               WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [9:0]       THR     = 10'(THRESHOLD);
    localparam logic [LSIZE-1:0] FULL    = LSIZE'(FULL_LEN);

    // A full burst must always fit on top of the threshold fill level.
    if (THRESHOLD + FULL_LEN > FIFO_DEPTH) begin : g_depth_check
        $error("THRESHOLD + FULL_LEN exceeds FIFO_DEPTH");
    end
    if (FULL_LEN >= (1 << LSIZE)) begin : g_len_check
        $error("FULL_LEN does not fit in LSIZE bits");
    end

    logic [2:0]      state;
    logic [WD_W-1:0] wd;
    logic            in_wait;

    assign in_wait = (state == BWAIT) || (state == TWAIT);

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            burst_req  <= 1'b0;
            tail_req   <= 1'b0;
            req_len    <= '0;
            burst_done <= 1'b0;
            tail_done  <= 1'b0;
            timeout    <= 1'b0;
            wd         <= '0;
        end else begin
            burst_done <= 1'b0;
            tail_done  <= 1'b0;
            timeout    <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable && fsync) state <= ARM;
                end
                ARM: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (count <= THR) begin
                        if (tail_status) begin
                            // A zero-length tail is reported as completed without a request.
                            if (tail_len != '0) begin
                                state    <= TREQ;
                                tail_req <= 1'b1;
                                req_len  <= tail_len;
                            end else begin
                                tail_done <= 1'b1;
                            end
                        end else begin
                            state     <= BREQ;
                            burst_req <= 1'b1;
                            req_len   <= FULL;
                        end
                    end
                end
                BREQ: begin
                    if (resp) begin
                        state     <= BWAIT;
                        burst_req <= 1'b0;
                    end
                end
                TREQ: begin
                    if (resp) begin
                        state    <= TWAIT;
                        tail_req <= 1'b0;
                    end
                end
                BWAIT: begin
                    if (done) begin
                        burst_done <= 1'b1;
                        state      <= enable ? ARM : IDLE;
                    end
                end
                TWAIT: begin
                    if (done) begin
                        tail_done <= 1'b1;
                        state     <= enable ? ARM : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Watchdog only ticks while waiting; an expiry restarts it and keeps waiting.
            if (in_wait && !done && (TIMEOUT != 0)) begin
                if (wd == WD_LAST) begin
                    timeout <= 1'b1;
                    wd      <= '0;
                end else begin
                    wd <= wd + 1'b1;
                end
            end else begin
                wd <= '0;
            end
        end
    end

endmodule

// File: tb/tb_read_line_burst_scheduler.sv
// Directed self-checking bench for read_line_burst_scheduler (TIMEOUT shortened to 16).
module tb_read_line_burst_scheduler;

    logic       clock = 1'b0;
    logic       rst, enable, fsync, tail_status, resp, done;
    logic [9:0] count;
    logic [8:0] tail_len;
    logic       burst_req, tail_req, burst_done, tail_done, timeout;
    logic [8:0] req_len;

    int errors = 0;
    int checks = 0;

    read_line_burst_scheduler #(
        .THRESHOLD(200), .FULL_LEN(256), .LSIZE(9), .FIFO_DEPTH(512), .TIMEOUT(16)
    ) dut (
        .clock(clock), .rst(rst), .enable(enable), .fsync(fsync), .count(count),
        .tail_status(tail_status), .tail_len(tail_len), .burst_req(burst_req),
        .tail_req(tail_req), .req_len(req_len), .resp(resp), .done(done),
        .burst_done(burst_done), .tail_done(tail_done), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // Advance one clock edge; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; count = 10'd0; enable = 1'b1; fsync = 1'b1;
        tail_status = 1'b0; tail_len = 9'd0; resp = 1'b0; done = 1'b0;
        tick(); tick(); tick();
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL rst_burst_req got=%0b exp=0", burst_req); end
        checks++; if (tail_req !== 1'b0) begin errors++; $display("FAIL rst_tail_req got=%0b exp=0", tail_req); end
        checks++; if (req_len !== 9'd0) begin errors++; $display("FAIL rst_req_len got=%0d exp=0", req_len); end
        checks++; if ({burst_done, tail_done, timeout} !== 3'b000) begin errors++; $display("FAIL rst_pulses got=%b exp=000", {burst_done, tail_done, timeout}); end
        rst = 1'b0; fsync = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if ({burst_req, tail_req} !== 2'b00) begin errors++; $display("FAIL rst_no_req_without_fsync got=%b exp=00", {burst_req, tail_req}); end
    endtask

    task automatic test_full_burst();
        count = 10'd100; enable = 1'b1; fsync = 1'b1;
        tick();
        fsync = 1'b0;
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL full_arm_no_req got=%0b exp=0", burst_req); end
        tick();
        checks++; if (burst_req !== 1'b1) begin errors++; $display("FAIL full_req got=%0b exp=1", burst_req); end
        checks++; if (req_len !== 9'd256) begin errors++; $display("FAIL full_req_len got=%0d exp=256", req_len); end
        checks++; if (tail_req !== 1'b0) begin errors++; $display("FAIL full_no_tail_req got=%0b exp=0", tail_req); end
        tick();
        checks++; if (burst_req !== 1'b1) begin errors++; $display("FAIL full_req_held got=%0b exp=1", burst_req); end
        resp = 1'b1;
        tick();
        resp = 1'b0; count = 10'd300;
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL full_req_drop got=%0b exp=0", burst_req); end
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (burst_done !== 1'b1) begin errors++; $display("FAIL full_burst_done got=%0b exp=1", burst_done); end
        tick();
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL full_burst_done_width got=%0b exp=0", burst_done); end
        tick(); tick();
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL full_no_req_above_thr got=%0b exp=0", burst_req); end
    endtask

    task automatic test_threshold();
        count = 10'd201;
        tick(); tick();
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL thr_201_no_req got=%0b exp=0", burst_req); end
        count = 10'd200;
        tick();
        checks++; if (burst_req !== 1'b1) begin errors++; $display("FAIL thr_200_req got=%0b exp=1", burst_req); end
        resp = 1'b1;
        tick();
        resp = 1'b0; count = 10'd300; done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (burst_done !== 1'b1) begin errors++; $display("FAIL thr_burst_done got=%0b exp=1", burst_done); end
    endtask

    task automatic test_tail();
        tail_status = 1'b1; tail_len = 9'd37; count = 10'd0;
        tick();
        checks++; if (tail_req !== 1'b1) begin errors++; $display("FAIL tail_req got=%0b exp=1", tail_req); end
        checks++; if (req_len !== 9'd37) begin errors++; $display("FAIL tail_req_len got=%0d exp=37", req_len); end
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL tail_no_burst_req got=%0b exp=0", burst_req); end
        resp = 1'b1;
        tick();
        resp = 1'b0; count = 10'd300;
        checks++; if (tail_req !== 1'b0) begin errors++; $display("FAIL tail_req_drop got=%0b exp=0", tail_req); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (tail_done !== 1'b1) begin errors++; $display("FAIL tail_done got=%0b exp=1", tail_done); end
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL tail_not_burst_done got=%0b exp=0", burst_done); end
        tick();
        checks++; if (tail_done !== 1'b0) begin errors++; $display("FAIL tail_done_width got=%0b exp=0", tail_done); end
        tail_len = 9'd0; count = 10'd0;
        tick();
        checks++; if (tail_done !== 1'b1) begin errors++; $display("FAIL tail_zero_done got=%0b exp=1", tail_done); end
        checks++; if (tail_req !== 1'b0) begin errors++; $display("FAIL tail_zero_no_req got=%0b exp=0", tail_req); end
        tail_status = 1'b0; count = 10'd300;
        tick();
        checks++; if ({tail_done, burst_req, tail_req} !== 3'b000) begin errors++; $display("FAIL tail_zero_quiet got=%b exp=000", {tail_done, burst_req, tail_req}); end
    endtask

    task automatic test_enable_drop();
        count = 10'd0;
        tick();
        checks++; if (burst_req !== 1'b1) begin errors++; $display("FAIL en_req got=%0b exp=1", burst_req); end
        enable = 1'b0; fsync = 1'b1;
        tick();
        fsync = 1'b0;
        checks++; if (burst_req !== 1'b1) begin errors++; $display("FAIL en_req_held got=%0b exp=1", burst_req); end
        tick();
        checks++; if (req_len !== 9'd256) begin errors++; $display("FAIL en_req_len_held got=%0d exp=256", req_len); end
        resp = 1'b1;
        tick();
        resp = 1'b0;
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL en_req_drop got=%0b exp=0", burst_req); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (burst_done !== 1'b1) begin errors++; $display("FAIL en_burst_done got=%0b exp=1", burst_done); end
        enable = 1'b1;
        tick(); tick();
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL en_parked_idle got=%0b exp=0", burst_req); end
    endtask

    task automatic test_watchdog();
        logic exp_to;
        count = 10'd0; fsync = 1'b1;
        tick();
        fsync = 1'b0;
        tick();
        checks++; if (burst_req !== 1'b1) begin errors++; $display("FAIL wd_req got=%0b exp=1", burst_req); end
        resp = 1'b1; count = 10'd300;
        tick();
        resp = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            tick();
            exp_to = (i == 16) || (i == 32);
            checks++; if (timeout !== exp_to) begin errors++; $display("FAIL wd_timeout_cycle%0d got=%0b exp=%0b", i, timeout, exp_to); end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (burst_done !== 1'b1) begin errors++; $display("FAIL wd_late_done got=%0b exp=1", burst_done); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_no_timeout_on_done got=%0b exp=0", timeout); end
    endtask

    task automatic test_reset_mid_burst();
        count = 10'd0;
        tick();
        checks++; if (burst_req !== 1'b1) begin errors++; $display("FAIL rstmid_req got=%0b exp=1", burst_req); end
        rst = 1'b1;
        tick();
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL rstmid_req_dropped got=%0b exp=0", burst_req); end
        checks++; if (req_len !== 9'd0) begin errors++; $display("FAIL rstmid_req_len got=%0d exp=0", req_len); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (burst_req !== 1'b0) begin errors++; $display("FAIL rstmid_idle_after got=%0b exp=0", burst_req); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_threshold();
        test_tail();
        test_enable_drop();
        test_watchdog();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
